inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
//  Sequences the two-pulse 8086-mode interrupt-acknowledge cycle of the PIC.
//  Raises INT toward the CPU and latches the winning IR level on the first INTA.
//  Issues the ISR-set/IRR-clear pulses and drives the vector byte on the second INTA,
//  gated by send_vector_address from the cascade logic. Handles automatic EOI.
//  Sits between the priority resolver, the ISR/IRR registers, the cascade block and the data-bus buffer.
// PARAMETERS
//  TIMEOUT  64  max clk cycles from 1st INTA fall to 2nd INTA fall before abort (>=4)
// PORTS
//  clk                  in   1  system clock; all logic on rising edge
//  reset                in   1  synchronous, active-high reset
//  INTA_n               in   1  CPU acknowledge strobe, active low, synchronous to clk
//  int_req              in   1  priority resolver: an unmasked IR outranks current ISR
//  highest_irq          in   3  index of winning IR level, valid when int_req=1
//  icw2_base            in   5  vector base T7..T3 from ICW2
//  aeoi                 in   1  ICW4 auto-EOI enable
//  send_vector_address  in   1  from cascade block: this device drives the vector
//  INT                  out  1  interrupt request to CPU
//  freeze               out  1  hold IRR/priority stable during acknowledge
//  isr_set              out  8  one-hot one-cycle pulse: set ISR bit
//  irr_clear            out  8  one-hot one-cycle pulse: clear IRR bit
//  isr_clear            out  8  one-hot one-cycle pulse: AEOI clear of ISR bit
//  data_out             out  8  vector byte {icw2_base, irq_lat}
//  data_oe              out  1  data bus drive enable
//  busy                 out  1  state != IDLE
// BEHAVIOUR
//  - inta_q: INTA_n registered, reset to 1. fall = inta_q & ~INTA_n. rise = ~inta_q & INTA_n.
//  - States: IDLE, REQ, ACK1, GAP, ACK2. All outputs registered; reset -> IDLE, every output 0.
//  - IDLE: int_req=1 -> REQ, INT=1 from the next cycle.
//  - REQ: fall -> ACK1; INT=0, freeze=1 from the next cycle.
//    - if int_req=1 at the fall: irq_lat=highest_irq; isr_set and irr_clear pulse bit irq_lat one cycle later.
//    - if int_req=0 at the fall (spurious): irq_lat=7, spurious flag set, no isr_set or irr_clear pulse.
//    - int_req dropping in REQ without a fall: stay in REQ, INT held high (spurious handled at INTA).
//  - ACK1: rise -> GAP; timeout counter cleared to 0.
//  - GAP: counter increments each cycle; fall -> ACK2; counter reaching TIMEOUT-1 -> IDLE (abort).
//    - Abort clears freeze; isr_set is not undone.
//  - ACK2: data_out={icw2_base,irq_lat} and data_oe=send_vector_address from the cycle after the 2nd fall.
//    - On rise: data_oe=0 next cycle; state -> IDLE; freeze=0.
//    - If aeoi=1 and not spurious, isr_clear pulses bit irq_lat on that same next cycle.
//  - data_out holds its last value when data_oe=0; it is 0 after reset.
//  - fall seen in IDLE (no INT raised) is ignored; no outputs change.
//  - INT may reassert at the earliest 1 cycle after returning to IDLE, if int_req=1.
//  - Simultaneous int_req change and fall: the int_req value at the fall cycle decides.
//  - reset mid-sequence: IDLE next cycle, data_oe/INT/freeze=0, no pending pulses emitted.
// TESTING
//  - int_req=1, highest_irq=3, icw2_base=5'h08, svA=1, two INTA pulses ->
//    INT 1 then 0; isr_set=irr_clear=8'h08 once; data_out=8'h43 with data_oe=1 during 2nd INTA.
//  - Same as above, aeoi=1 -> isr_clear=8'h08 for one cycle after 2nd INTA rise; aeoi=0 -> isr_clear stays 0.
//  - int_req drops before 1st INTA -> no isr_set or irr_clear; data_out={base,3'd7}; isr_clear=0 even with aeoi=1.
//  - svA=0 (master with cascaded slave at IR2) -> full handshake runs, isr_set=8'h04, data_oe never asserts.
//  - TIMEOUT=8, only 1st INTA given -> returns to IDLE after 8 GAP cycles; freeze=0; busy=0.
//  - reset asserted during ACK2 -> data_oe=0, busy=0 next cycle; new int_req then raises INT normally.

Source files
------------

// File: rtl/inta_sequencer.sv
// Two-pulse 8086-mode interrupt-acknowledge sequencer for the PIC.
// Raises INT, latches the winning IR on the first INTA and drives the vector on the second.
module inta_sequencer #(
  parameter int unsigned Timeout = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       inta_n_i,
  input  logic       int_req_i,
  input  logic [2:0] highest_irq_i,
  input  logic [4:0] icw2_base_i,
  input  logic       aeoi_i,
  input  logic       send_vector_address_i,
  output logic       int_o,
  output logic       freeze_o,
  output logic [7:0] isr_set_o,
  output logic [7:0] irr_clear_o,
  output logic [7:0] isr_clear_o,
  output logic [7:0] data_out_o,
  output logic       data_oe_o,
  output logic       busy_o
);

  localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StAck1 = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StAck2 = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            inta_q;
  logic [2:0]      irq_lat_q, irq_lat_d;
  logic            spur_q, spur_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            int_q, int_d;
  logic            freeze_q, freeze_d;
  logic [7:0]      isr_set_q, isr_set_d;
  logic [7:0]      irr_clear_q, irr_clear_d;
  logic [7:0]      isr_clear_q, isr_clear_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            fall, rise;

  assign fall = inta_q & ~inta_n_i;
  assign rise = ~inta_q & inta_n_i;

  always_comb begin
    state_d     = state_q;
    irq_lat_d   = irq_lat_q;
    spur_d      = spur_q;
    cnt_d       = cnt_q;
    int_d       = int_q;
    freeze_d    = freeze_q;
    isr_set_d   = '0;
    irr_clear_d = '0;
    isr_clear_d = '0;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;

    case (state_q)
      StIdle: begin
        if (int_req_i) begin
          state_d = StReq;
          int_d   = 1'b1;
        end
      end
      StReq: begin
        // int_req sampled at the fall decides between a real and a spurious acknowledge
        if (fall) begin
          state_d  = StAck1;
          int_d    = 1'b0;
          freeze_d = 1'b1;
          if (int_req_i) begin
            irq_lat_d   = highest_irq_i;
            spur_d      = 1'b0;
            isr_set_d   = 8'd1 << highest_irq_i;
            irr_clear_d = 8'd1 << highest_irq_i;
          end else begin
            irq_lat_d = 3'd7;
            spur_d    = 1'b1;
          end
        end
      end
      StAck1: begin
        if (rise) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (fall) begin
          state_d    = StAck2;
          data_out_d = {icw2_base_i, irq_lat_q};
          data_oe_d  = send_vector_address_i;
        end else if (cnt_q == CntW'(Timeout - 1)) begin
          // Abort: ISR bit already set stays set
          state_d  = StIdle;
          freeze_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck2: begin
        if (rise) begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
          freeze_d  = 1'b0;
          if (aeoi_i && !spur_q) begin
            isr_clear_d = 8'd1 << irq_lat_q;
          end
        end else begin
          data_out_d = {icw2_base_i, irq_lat_q};
          data_oe_d  = send_vector_address_i;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      irq_lat_q   <= '0;
      spur_q      <= 1'b0;
      cnt_q       <= '0;
      int_q       <= 1'b0;
      freeze_q    <= 1'b0;
      isr_set_q   <= '0;
      irr_clear_q <= '0;
      isr_clear_q <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n_i;
      irq_lat_q   <= irq_lat_d;
      spur_q      <= spur_d;
      cnt_q       <= cnt_d;
      int_q       <= int_d;
      freeze_q    <= freeze_d;
      isr_set_q   <= isr_set_d;
      irr_clear_q <= irr_clear_d;
      isr_clear_q <= isr_clear_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign int_o       = int_q;
  assign freeze_o    = freeze_q;
  assign isr_set_o   = isr_set_q;
  assign irr_clear_o = irr_clear_q;
  assign isr_clear_o = isr_clear_q;
  assign data_out_o  = data_out_q;
  assign data_oe_o   = data_oe_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed handshakes then randomized transactions,
// with expected outputs derived per transaction from its parameters.
module tb_inta_sequencer;

  localparam int unsigned Tmo = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       inta_n;
  logic       int_req;
  logic [2:0] highest_irq;
  logic [4:0] icw2_base;
  logic       aeoi;
  logic       sva;
  logic       int_out;
  logic       freeze;
  logic [7:0] isr_set;
  logic [7:0] irr_clear;
  logic [7:0] isr_clear;
  logic [7:0] data_out;
  logic       data_oe;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.Timeout(Tmo)) dut (
    .clk_i                 (clk),
    .reset_i               (reset),
    .inta_n_i              (inta_n),
    .int_req_i             (int_req),
    .highest_irq_i         (highest_irq),
    .icw2_base_i           (icw2_base),
    .aeoi_i                (aeoi),
    .send_vector_address_i (sva),
    .int_o                 (int_out),
    .freeze_o              (freeze),
    .isr_set_o             (isr_set),
    .irr_clear_o           (irr_clear),
    .isr_clear_o           (isr_clear),
    .data_out_o            (data_out),
    .data_oe_o             (data_oe),
    .busy_o                (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full acknowledge transaction; expectations follow from the transaction parameters.
  task automatic run_txn(input int irq, input logic [4:0] base, input bit ae, input bit sv,
                         input bit drop, input int gapw, input bit rst_ack2);
    logic [7:0] oh;
    logic [2:0] lat;
    int         n;
    oh  = drop ? 8'h00 : (8'd1 << irq);
    lat = drop ? 3'd7 : 3'(irq);
    icw2_base   = base;
    aeoi        = ae;
    sva         = sv;
    highest_irq = 3'(irq);
    int_req     = 1'b1;
    tick;
    chk("int_raise", int_out, 1);
    chk("busy_req", busy, 1);
    chk("freeze_req", freeze, 0);
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick;
      chk("int_hold", int_out, 1);
    end
    if (drop) begin
      int_req = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        tick;
        chk("int_hold_drop", int_out, 1);
      end
    end
    inta_n = 1'b0;
    tick;
    chk("int_ack1", int_out, 0);
    chk("freeze_ack1", freeze, 1);
    chk("isr_set", isr_set, oh);
    chk("irr_clear", irr_clear, oh);
    int_req     = 1'b0;
    highest_irq = 3'($urandom);
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick;
      chk("isr_set_once", isr_set, 0);
    end
    inta_n = 1'b1;
    tick;
    chk("freeze_gap", freeze, 1);
    chk("busy_gap", busy, 1);
    if (gapw >= int'(Tmo)) begin
      for (int i = 0; i < int'(Tmo); i++) begin
        tick;
        chk("gap_busy", busy, (i + 1 < int'(Tmo)) ? 1 : 0);
      end
      chk("abort_freeze", freeze, 0);
      chk("abort_int", int_out, 0);
      chk("abort_oe", data_oe, 0);
      tick;
      return;
    end
    repeat (gapw) tick;
    inta_n = 1'b0;
    tick;
    chk("vector", data_out, {base, lat});
    chk("oe_ack2", data_oe, sv);
    chk("busy_ack2", busy, 1);
    if (rst_ack2) begin
      reset = 1'b1;
      tick;
      chk("rst_oe", data_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_freeze", freeze, 0);
      chk("rst_int", int_out, 0);
      chk("rst_isr_clear", isr_clear, 0);
      reset  = 1'b0;
      inta_n = 1'b1;
      tick;
      chk("post_rst_busy", busy, 0);
      return;
    end
    n = $urandom_range(0, 2);
    repeat (n) begin
      tick;
      chk("oe_hold", data_oe, sv);
      chk("isr_clear_early", isr_clear, 0);
    end
    inta_n = 1'b1;
    tick;
    chk("oe_end", data_oe, 0);
    chk("busy_end", busy, 0);
    chk("freeze_end", freeze, 0);
    chk("aeoi", isr_clear, (ae && !drop) ? oh : 8'h00);
    chk("vector_hold", data_out, {base, lat});
    tick;
    chk("aeoi_once", isr_clear, 0);
    chk("int_idle", int_out, 0);
  endtask

  initial begin
    reset       = 1'b1;
    inta_n      = 1'b1;
    int_req     = 1'b0;
    highest_irq = 3'd0;
    icw2_base   = 5'd0;
    aeoi        = 1'b0;
    sva         = 1'b0;
    tick;
    tick;
    chk("rst_int", int_out, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_isr_set", isr_set, 0);
    chk("rst_irr_clear", irr_clear, 0);
    chk("rst_isr_clear", isr_clear, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick;

    // INTA fall while idle is ignored
    inta_n = 1'b0;
    tick;
    chk("idle_fall_busy", busy, 0);
    chk("idle_fall_int", int_out, 0);
    chk("idle_fall_freeze", freeze, 0);
    inta_n = 1'b1;
    tick;

    run_txn(3, 5'h08, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    run_txn(3, 5'h08, 1'b1, 1'b1, 1'b0, 1, 1'b0);
    run_txn(5, 5'h11, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    run_txn(2, 5'h1f, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_txn(6, 5'h0a, 1'b0, 1'b1, 1'b0, Tmo, 1'b0);
    run_txn(7, 5'h05, 1'b1, 1'b1, 1'b0, Tmo - 1, 1'b0);
    run_txn(1, 5'h13, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    run_txn(4, 5'h02, 1'b1, 1'b1, 1'b0, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      run_txn($urandom_range(0, 7), 5'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 4) == 0), $urandom_range(0, Tmo + 1),
              ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule
